// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: walks a ROM sprite row-major, clips to the screen and writes texels via valid/ready.
// Latency 2 cycles start->first fb_we; 2 cycles per written pixel, 1 per skipped; fb_ready low stalls in WRITE.
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENCY_EN.
module sprite_blit_ctrl #(
   parameter int          SCREEN_W  = 320,
   parameter int          SCREEN_H  = 240,
   parameter logic [15:0] KEY_COLOR = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [8:0]  pos_x,
   input  logic [8:0]  pos_y,
   output logic [16:0] rom_pixel,
   input  logic [15:0] rom_color,
   input  logic [8:0]  rom_width,
   input  logic [8:0]  rom_height,
   output logic        fb_we,
   output logic [16:0] fb_addr,
   output logic [15:0] fb_data,
   input  logic        fb_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state;
   logic [8:0]  org_x, org_y, spr_w, spr_h;
   logic [8:0]  col, row;
   logic [9:0]  sx, sy;
   logic        clipped, is_key, skip, last_texel;
   logic [16:0] addr_calc;

   // 10-bit sums so a sprite hanging off the right/bottom edge never wraps back on screen.
   assign sx         = {1'b0, org_x} + {1'b0, col};
   assign sy         = {1'b0, org_y} + {1'b0, row};
   assign clipped    = (sx >= 10'(SCREEN_W)) || (sy >= 10'(SCREEN_H));
   assign last_texel = (col == spr_w - 9'd1) && (row == spr_h - 9'd1);
   assign addr_calc  = 17'(sy) * 17'(SCREEN_W) + 17'(sx);

`ifdef SPRITE_TRANSPARENCY_EN
   assign is_key = (rom_color == KEY_COLOR);
`else
   logic unused_key;
   assign unused_key = ^KEY_COLOR;
   assign is_key     = 1'b0;
`endif

   assign skip = clipped || is_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         org_x     <= '0;
         org_y     <= '0;
         spr_w     <= '0;
         spr_h     <= '0;
         col       <= '0;
         row       <= '0;
         rom_pixel <= '0;
         fb_we     <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !busy) begin
                  org_x     <= pos_x;
                  org_y     <= pos_y;
                  spr_w     <= rom_width;
                  spr_h     <= rom_height;
                  col       <= '0;
                  row       <= '0;
                  rom_pixel <= '0;
                  busy      <= 1'b1;
                  state     <= (rom_width == 9'd0 || rom_height == 9'd0) ? S_DONE : S_FETCH;
               end else begin
                  busy <= 1'b0;
               end
            end
            S_FETCH: begin
               if (skip) begin
                  if (last_texel) begin
                     state <= S_DONE;
                  end else begin
                     rom_pixel <= rom_pixel + 17'd1;
                     if (col == spr_w - 9'd1) begin
                        col <= '0;
                        row <= row + 9'd1;
                     end else begin
                        col <= col + 9'd1;
                     end
                  end
               end else begin
                  fb_addr <= addr_calc;
                  fb_data <= rom_color;
                  fb_we   <= 1'b1;
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (fb_ready) begin
                  fb_we <= 1'b0;
                  if (last_texel) begin
                     state <= S_DONE;
                  end else begin
                     state     <= S_FETCH;
                     rom_pixel <= rom_pixel + 17'd1;
                     if (col == spr_w - 9'd1) begin
                        col <= '0;
                        row <= row + 9'd1;
                     end else begin
                        col <= col + 9'd1;
                     end
                  end
               end
            end
            default: begin
               // busy stays high through the done pulse and drops in IDLE on the following edge.
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
